// File: rtl/econet_pkg.sv
// Shared definitions for the Econet collision-detect block: FSM encoding,
// register word layout and reset values.
package econet_pkg;

    localparam int DATA_W = 32;
    localparam int LANES  = DATA_W / 8;
    localparam int FILT_W = 4;
    localparam int EVC_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RISE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_FALL   = 2'd3
    } coldet_fsm_e;

    localparam int BIT_IRQ_EN = 0;
    localparam int BIT_STICKY = 1;
    localparam int BIT_STATE  = 2;
    localparam int BIT_SYNC   = 3;
    localparam int FILT_LSB   = 8;
    localparam int EVC_LSB    = 16;

    localparam int LANE_CTRL  = 0;
    localparam int LANE_FILT  = 1;
    localparam int LANE_EVC   = 2;

    localparam logic [FILT_W-1:0] FILT_LEN_RST = 4'h3;

endpackage

// File: rtl/econet_coldet_if.sv
// Register bus between a host and the collision-detect block.
interface econet_coldet_if;
    import econet_pkg::*;

    logic [LANES-1:0]  wr;
    logic              select;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    modport master (
        output wr,
        output select,
        output data_in,
        input  data_out
    );

    modport slave (
        input  wr,
        input  select,
        input  data_in,
        output data_out
    );

endinterface

// File: rtl/econet_sync2.sv
// Two-flop synchronizer for asynchronous Econet line inputs.
module econet_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/econet_coldet.sv
// Econet collision detector: synchronizes the raw collision line, debounces it
// with a programmable run-length filter and reports events via a register word.
module econet_coldet
    import econet_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    econet_coldet_if.slave  bus,
    input  logic            collision_detect,
    output logic            coldet_state,
    output logic            coldet_interrupt
);

    localparam logic [FILT_W-1:0] RUN_ONE = {{(FILT_W-1){1'b0}}, 1'b1};
    localparam logic [EVC_W-1:0]  EVC_ONE = {{(EVC_W-1){1'b0}}, 1'b1};

    function automatic logic [EVC_W-1:0] sat_inc(input logic [EVC_W-1:0] v);
        return (v == {EVC_W{1'b1}}) ? v : v + EVC_ONE;
    endfunction

    logic              sync_raw;
    coldet_fsm_e       state_q;
    coldet_fsm_e       state_d;
    logic [FILT_W-1:0] run_q;
    logic [FILT_W-1:0] run_d;
    logic              run_done;
    logic              event_rise;

    logic              irq_en_q;
    logic              sticky_q;
    logic [FILT_W-1:0] filt_len_q;
    logic [EVC_W-1:0]  evcount_q;

    logic              wr_en;
    logic [LANES-1:0]  lane_we;

    econet_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (collision_detect),
        .q     (sync_raw)
    );

    assign wr_en   = bus.select && (bus.wr != '0);
    assign lane_we = wr_en ? bus.wr : '0;

    // Comparing against the live filt_len lets a lowered threshold finish a run at once.
    assign run_done = (run_q >= filt_len_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        event_rise = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sync_raw) begin
                    if (filt_len_q == '0) begin
                        state_d    = ST_ACTIVE;
                        run_d      = '0;
                        event_rise = 1'b1;
                    end else begin
                        state_d = ST_RISE;
                        run_d   = RUN_ONE;
                    end
                end
            end
            ST_RISE: begin
                if (!sync_raw) begin
                    state_d = ST_IDLE;
                    run_d   = '0;
                end else if (run_done) begin
                    state_d    = ST_ACTIVE;
                    run_d      = '0;
                    event_rise = 1'b1;
                end else begin
                    run_d = run_q + RUN_ONE;
                end
            end
            ST_ACTIVE: begin
                if (!sync_raw) begin
                    if (filt_len_q == '0) begin
                        state_d = ST_IDLE;
                        run_d   = '0;
                    end else begin
                        state_d = ST_FALL;
                        run_d   = RUN_ONE;
                    end
                end
            end
            ST_FALL: begin
                if (sync_raw) begin
                    state_d = ST_ACTIVE;
                    run_d   = '0;
                end else if (run_done) begin
                    state_d = ST_IDLE;
                    run_d   = '0;
                end else begin
                    run_d = run_q + RUN_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                run_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_en_q   <= 1'b0;
            sticky_q   <= 1'b0;
            filt_len_q <= FILT_LEN_RST;
            evcount_q  <= '0;
        end else begin
            if (lane_we[LANE_CTRL]) begin
                irq_en_q <= bus.data_in[BIT_IRQ_EN];
            end
            // A new event outranks a simultaneous write-one-to-clear.
            if (event_rise) begin
                sticky_q <= 1'b1;
            end else if (lane_we[LANE_CTRL] && bus.data_in[BIT_STICKY]) begin
                sticky_q <= 1'b0;
            end
            if (lane_we[LANE_FILT]) begin
                filt_len_q <= bus.data_in[FILT_LSB +: FILT_W];
            end
            if (lane_we[LANE_EVC]) begin
                evcount_q <= event_rise ? EVC_ONE : '0;
            end else if (event_rise) begin
                evcount_q <= sat_inc(evcount_q);
            end
        end
    end

    assign coldet_state     = (state_q == ST_ACTIVE) || (state_q == ST_FALL);
    assign coldet_interrupt = sticky_q & irq_en_q;

    always_comb begin
        bus.data_out                          = '0;
        bus.data_out[BIT_IRQ_EN]              = irq_en_q;
        bus.data_out[BIT_STICKY]              = sticky_q;
        bus.data_out[BIT_STATE]               = coldet_state;
        bus.data_out[BIT_SYNC]                = sync_raw;
        bus.data_out[FILT_LSB +: FILT_W]      = filt_len_q;
        bus.data_out[EVC_LSB +: EVC_W]        = evcount_q;
    end

endmodule

// File: doc/econet_coldet.md
ECONET_COLDET -- requirements
Module: econet_coldet

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low reset; low at a clk edge resets the block.
REQ-003 SHALL have port: wr  input  4  byte-lane write strobes; lane n covers data_in[8n+7:8n].
REQ-004 SHALL have port: select  input  1  register select; a write occurs only when select=1 and wr!=0.
REQ-005 SHALL have port: data_in  input  32  write data.
REQ-006 SHALL have port: data_out  output  32  combinational register readback, independent of select.
REQ-007 SHALL have port: collision_detect  input  1  raw Econet collision line, asynchronous, active-high.
REQ-008 SHALL have port: coldet_state  output  1  filtered collision state.
REQ-009 SHALL have port: coldet_interrupt  output  1  level interrupt, equal to sticky AND irq_en.

Function
REQ-010 Register word SHALL be: bit0 irq_en (RW, lane 0); bit1 sticky (W1C, lane 0); bit2 coldet_state (RO); bit3 sync_raw (RO); bits11:8 filt_len (RW, lane 1); bits23:16 evcount (RO; any lane-2 write clears to 0); all other bits read 0.
REQ-011 collision_detect SHALL pass through a two-flop synchronizer; sync_raw is the second-flop output.
REQ-012 FSM states SHALL be IDLE, RISE, ACTIVE and FALL; coldet_state is 1 in ACTIVE and FALL, 0 otherwise.
REQ-013 IDLE->RISE when sync_raw=1; ACTIVE->FALL when sync_raw=0; on each such transition the run counter loads 1.
REQ-014 In RISE, each edge with sync_raw=1 increments the run counter; on the edge where the counter equals filt_len (or immediately if filt_len=0) the FSM SHALL enter ACTIVE.
REQ-015 In RISE, sync_raw=0 returns to IDLE; in FALL, sync_raw=1 returns to ACTIVE; the run counter clears, with no event and no sticky change.
REQ-016 FALL->IDLE SHALL use the same filt_len+1 consecutive-sample rule as RISE->ACTIVE.
REQ-017 Latency: a raw level first sampled at edge 0 and held SHALL change coldet_state at edge filt_len+2.
REQ-018 Changing filt_len mid-count SHALL apply on the next edge; a run counter already at or above the new threshold completes the transition on that edge.
REQ-019 On the edge RISE->ACTIVE, sticky SHALL set and evcount SHALL increment, saturating at 255.
REQ-020 If sticky sets and a W1C of bit1 occur on the same edge, set SHALL win; a W1C of 0 SHALL have no effect.
REQ-021 If an evcount increment and a lane-2 clear occur on the same edge, evcount SHALL become 1.
REQ-022 coldet_interrupt SHALL assert on the same edge sticky sets (if irq_en=1) and SHALL deassert on the edge sticky clears or irq_en is written 0.

Reset
REQ-023 On reset=0 at a clk edge: synchronizer flops 0, FSM IDLE, run counter 0, irq_en 0, sticky 0, filt_len 4'h3, evcount 0.
REQ-024 Resulting outputs SHALL be coldet_state=0 and coldet_interrupt=0; reset mid-filter SHALL abandon the run with no event.
REQ-025 Reset SHALL take priority over any simultaneous write.

Structure
REQ-026 Shared package econet_pkg SHALL hold the FSM state encoding, register bit positions and the filt_len reset value.
REQ-027 The synchronizer SHALL be a separate sub-module, econet_sync2, which is reused by other Econet blocks.

Verification
REQ-028 Test 1: after reset, read -> 0x00000300; coldet_interrupt=0.
REQ-029 Test 2: filt_len=3, irq_en=1, raw held high from edge 0 -> coldet_state, sticky and interrupt assert at edge 5; evcount=1.
REQ-030 Test 3: filt_len=3, raw high for 3 cycles only -> coldet_state stays 0; evcount=0; sticky=0.
REQ-031 Test 4: W1C bit1 on the same edge as a new RISE->ACTIVE -> sticky remains 1; separate W1C -> sticky 0, interrupt 0 next edge.
REQ-032 Test 5: 260 qualified collisions -> evcount=255; lane-2 write -> 0; clear coinciding with an event -> 1.
REQ-033 Test 6: reset=0 mid-RISE with filt_len=7 -> IDLE, no event; filt_len lowered from 7 to 2 with counter=4 -> ACTIVE on the next edge.
